// File: rtl/param_datapath.sv
// Multi-cycle register-file datapath: a five-state sequencer reads two operands,
// runs a shift/ALU step and writes one of four sources back to the register file.
module param_datapath #(
  parameter int W   = 16,
  parameter int RW  = 3,
  parameter int PCW = 9
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic           start,
  output logic           ready,
  output logic           done,
  input  logic [RW-1:0]  rn,
  input  logic [RW-1:0]  rm,
  input  logic [RW-1:0]  rd,
  input  logic [1:0]     op_alu,
  input  logic [1:0]     op_shift,
  input  logic           asel,
  input  logic           bsel,
  input  logic [W-1:0]   imm5,
  input  logic [W-1:0]   imm8,
  input  logic [1:0]     vsel,
  input  logic [PCW-1:0] pc,
  input  logic [W-1:0]   mdata,
  input  logic           wr_en,
  input  logic           set_status,
  output logic [W-1:0]   result,
  output logic [2:0]     status,
  output logic [PCW-1:0] lr
);

  localparam int NREG = 2**RW;

  typedef enum logic [2:0] {S_IDLE, S_RDA, S_RDB, S_EXEC, S_WB} state_t;

  state_t r_state, w_next;
  logic   w_accept;

  logic [RW-1:0]         r_rn, r_rm, r_rd;
  logic [1:0]            r_op_alu, r_op_shift, r_vsel;
  logic                  r_asel, r_bsel, r_wr_en, r_set_status;
  logic signed [W-1:0]   r_imm5, r_imm8;
  logic [PCW-1:0]        r_pc;

  logic signed [W-1:0]   r_rf [NREG];
  logic signed [W-1:0]   r_a, r_b, r_c;
  logic [2:0]            r_status;

  logic signed [W-1:0]   w_opa, w_opb, w_alu, w_wb_data;
  logic                  w_ovf;
  logic [PCW-1:0]        w_pc_inc;

  function automatic logic signed [W-1:0] f_shift(input logic signed [W-1:0] b,
                                                  input logic [1:0] op);
    logic signed [W-1:0] s;
    case (op)
      2'b01:   s = {b[W-2:0], 1'b0};
      2'b10:   s = {1'b0, b[W-1:1]};
      2'b11:   s = {b[W-1], b[W-1:1]};
      default: s = b;
    endcase
    return s;
  endfunction

  function automatic logic signed [W-1:0] f_alu(input logic signed [W-1:0] a,
                                                input logic signed [W-1:0] b,
                                                input logic [1:0] op);
    logic signed [W-1:0] s;
    case (op)
      2'b00:   s = a + b;
      2'b01:   s = a - b;
      2'b10:   s = a & b;
      default: s = ~b;
    endcase
    return s;
  endfunction

  // Overflow only exists for add/sub; logic ops always report V=0.
  function automatic logic f_ovf(input logic signed [W-1:0] a,
                                 input logic signed [W-1:0] b,
                                 input logic signed [W-1:0] s,
                                 input logic [1:0] op);
    logic v;
    case (op)
      2'b00:   v = (a[W-1] == b[W-1]) && (s[W-1] != a[W-1]);
      2'b01:   v = (a[W-1] != b[W-1]) && (s[W-1] != a[W-1]);
      default: v = 1'b0;
    endcase
    return v;
  endfunction

  assign w_accept = start && (r_state == S_IDLE);
  assign w_opa    = r_asel ? '0 : r_a;
  assign w_opb    = r_bsel ? r_imm5 : f_shift(r_b, r_op_shift);
  assign w_alu    = f_alu(w_opa, w_opb, r_op_alu);
  assign w_ovf    = f_ovf(w_opa, w_opb, w_alu, r_op_alu);
  assign w_pc_inc = r_pc + PCW'(1);

  always_comb begin
    w_wb_data = r_c;
    case (r_vsel)
      2'b01: begin
        w_wb_data = '0;
        w_wb_data[PCW-1:0] = w_pc_inc;
      end
      2'b10:   w_wb_data = r_imm8;
      2'b11:   w_wb_data = mdata;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    ready  = 1'b0;
    done   = 1'b0;
    case (r_state)
      S_IDLE: begin
        ready = 1'b1;
        if (start) w_next = S_RDA;
      end
      S_RDA:  w_next = S_RDB;
      S_RDB:  w_next = S_EXEC;
      S_EXEC: w_next = S_WB;
      S_WB: begin
        done   = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Command fields are frozen at acceptance; mdata alone is read live at writeback.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_rn         <= rn;
      r_rm         <= rm;
      r_rd         <= rd;
      r_op_alu     <= op_alu;
      r_op_shift   <= op_shift;
      r_asel       <= asel;
      r_bsel       <= bsel;
      r_imm5       <= imm5;
      r_imm8       <= imm8;
      r_vsel       <= vsel;
      r_pc         <= pc;
      r_wr_en      <= wr_en;
      r_set_status <= set_status;
    end
  end

  // Operand fetch (RDA/RDB) and execute (EXEC) stages.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_a      <= '0;
      r_b      <= '0;
      r_c      <= '0;
      r_status <= '0;
    end else begin
      case (r_state)
        S_RDA: r_a <= r_rf[r_rn];
        S_RDB: r_b <= r_rf[r_rm];
        S_EXEC: begin
          r_c <= w_alu;
          if (r_set_status) r_status <= {w_ovf, w_alu[W-1], (w_alu == '0)};
        end
        default: ;
      endcase
    end
  end

  // Writeback stage.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NREG; i++) r_rf[i] <= '0;
    end else if (r_state == S_WB && r_wr_en) begin
      r_rf[r_rd] <= w_wb_data;
    end
  end

  assign result = r_c;
  assign status = r_status;
  assign lr     = r_a[PCW-1:0];

endmodule

// File: doc/param_datapath.md
PARAM_DATAPATH -- requirements
Module: param_datapath

Interface
REQ-001 Parameter W, default 16, datapath and register-file word width (W >= 8).
REQ-002 Parameter RW, default 3, register-address width; the register file SHALL hold 2**RW words.
REQ-003 Parameter PCW, default 9, program-counter and link-register width (PCW <= W).
REQ-004 clk  in  1  sole clock; all state SHALL update on its rising edge.
REQ-005 reset_n  in  1  asynchronous, active-low reset.
REQ-006 start  in  1  command request, sampled only while ready=1.
REQ-007 ready  out  1  high when idle and able to accept start.
REQ-008 done  out  1  one-cycle pulse marking command completion.
REQ-009 rn, rm, rd  in  RW each  A-operand, B-operand and destination register addresses.
REQ-010 op_alu  in  2  00 add, 01 sub (A-B), 10 and, 11 not B.
REQ-011 op_shift  in  2  applied to B: 00 none, 01 shl 1 (lsb 0), 10 lsr 1 (msb 0), 11 asr 1 (msb kept).
REQ-012 asel, bsel  in  1 each  asel=1 forces A operand to 0; bsel=1 selects imm5 instead of shifted B.
REQ-013 imm5, imm8  in  W each  pre-sign-extended immediates.
REQ-014 vsel  in  2  writeback source: 00 C, 01 pc+1, 10 imm8, 11 mdata.
REQ-015 pc  in  PCW  current program counter; mdata  in  W  memory read data.
REQ-016 wr_en, set_status  in  1 each  enable register writeback, enable status update.
REQ-017 result  out  W  C register contents.
REQ-018 status  out  3  [0] Z, [1] N, [2] V.
REQ-019 lr  out  PCW  A register bits [PCW-1:0].

Function
REQ-020 All command inputs except mdata SHALL be latched on the start edge; later changes SHALL have no effect until the next accepted start.
REQ-021 mdata SHALL be sampled at the writeback edge.
REQ-022 FSM states SHALL be IDLE, RDA, RDB, EXEC, WB; IDLE->RDA on start, then unconditionally RDA->RDB->EXEC->WB->IDLE.
REQ-023 ready SHALL be 1 only in IDLE; start outside IDLE SHALL be ignored.
REQ-024 RDA SHALL load A from reg[rn]; RDB SHALL load B from reg[rm]; EXEC SHALL load C with the ALU output and, if set_status, load status.
REQ-025 done SHALL be 1 exactly during WB; if wr_en, reg[rd] SHALL be written at the end of WB.
REQ-026 Latency: start accepted at edge 0, done high between edges 3 and 4, register write at edge 4, ready high again after edge 4; accepted commands are 5 cycles apart at best.
REQ-027 Arithmetic SHALL be modulo 2**W.
REQ-028 Z SHALL be (ALU out == 0); N SHALL be ALU out[W-1].
REQ-029 V SHALL be signed overflow for add/sub and 0 for and/not.
REQ-030 pc+1 SHALL be computed in PCW bits (all-ones wraps to 0) and zero-extended to W.
REQ-031 When rd equals rn or rm, the operands SHALL be the pre-write values; the write is visible to the next command.
REQ-032 start held high continuously SHALL launch a new command on each IDLE cycle.

Reset
REQ-033 reset_n low SHALL immediately force: state IDLE, all register-file words 0, A=B=C=0, status=000, done=0, ready=1, result=0, lr=0.
REQ-034 Reset asserted mid-command SHALL abort it with no register-file or status write.
REQ-035 Normal operation SHALL resume on the first rising clk edge after reset_n rises.

Verification
REQ-036 Reset, then command to write imm8=0x0005 to r1 (vsel=10, wr_en=1); then command to write imm8=0x0003 to r2 -> r1=0x0005, r2=0x0003; done pulses 4 cycles after each start.
REQ-037 r1=0x7FFF, r2=0x0001, op_alu=00, set_status=1, rd=r3 -> r3=0x8000, status=110 (V=1, N=1, Z=0).
REQ-038 r1=0x8001, op_alu=11, op_shift=11, rm=r1 -> C=not(0xC000)=0x3FFF; with set_status=0, status unchanged.
REQ-039 pc=0x1FF (PCW=9), vsel=01 -> rd=0x0000; pc=0x010 -> rd=0x0011; lr=A[8:0] after RDA.
REQ-040 start pulsed during RDB is ignored; reset_n pulsed low during EXEC -> no write, all registers 0, ready=1 immediately.
REQ-041 rd=rn=r4 with r4=0x0002, r4+r4 -> r4=0x0004; a second identical command -> r4=0x0008.
